dram_ctrl: RTL and testbench
============================

# dram_ctrl

Sequential DRAM controller sitting directly downstream of the mmu8722. It takes the MMU's translated CPU address (TA15..TA0) and RAM bank select and drives the multiplexed address, RAS/CAS strobes and write enable for two 64 KB DRAM banks. It also generates periodic RAS-only refresh, arbitrating refresh against CPU accesses. It replaces the discrete address-multiplexer and strobe-timing logic of the original board.

## Interface
Parameters:
- REFRESH_INTERVAL, 124: clk cycles between refresh requests (≥16).
- TRP, 2: precharge cycles after each access or refresh (≥1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  single-cycle access request; accepted only when busy=0.
- rw  in  1  1=read, 0=write; sampled with req.
- ta  in  16  translated address from mmu8722; sampled with req.
- bank  in  1  RAM bank from mmu8722 (0→cas0_n, 1→cas1_n); sampled with req.
- ma  out  8  multiplexed DRAM address.
- ras_n  out  1  row strobe, common to both banks.
- cas0_n  out  1  column strobe, bank 0.
- cas1_n  out  1  column strobe, bank 1.
- we_n  out  1  DRAM write enable.
- busy  out  1  controller not accepting requests.
- done  out  1  one-cycle pulse; the access has completed (read data valid on this cycle).

## Operation
- Reset (reset_n=0, asynchronous, any state): ma=8'h00, ras_n=cas0_n=cas1_n=we_n=1, busy=0, done=0, refresh row counter=0, refresh timer=0, ref_pending=0, req_pending=0, state=IDLE.
- Refresh timer free-runs from 0 and counts to REFRESH_INTERVAL-1, then wraps to 0 and sets ref_pending.
  - If ref_pending is already set when the timer fires, it stays set. Missed refreshes are not counted.
- Request capture: if req=1 and busy=0 on an edge, latch ta, rw and bank, and set req_pending.
- Arbitration in IDLE: ref_pending has priority over req_pending.
  - A request arriving in the same cycle that a refresh starts is held and served immediately after that refresh's precharge.
- Access states:
  - ROW: ma=ta[7:0], strobes high.
  - RAS: ras_n=0.
  - COL: ma=ta[15:8]; we_n=0 if write.
  - CAS: selected cas_n=0; the other cas_n stays 1.
  - HOLD: strobes held.
  - PRE: ras_n, cas_n and we_n all 1, done=1 for the first PRE cycle only; remain TRP cycles, then IDLE. req_pending clears on entry to PRE.
- Refresh states:
  - RROW: ma=refresh row counter.
  - RRAS: ras_n=0 for 2 cycles; both cas_n stay 1, we_n=1.
  - PRE: TRP cycles. Refresh row counter increments on entry to PRE and wraps 8'hFF→8'h00. ref_pending clears on entry to RROW.
- busy=1 in every state except IDLE, and also in IDLE while ref_pending or req_pending is set.
- ma holds its last value in IDLE and PRE.
- cas0_n and cas1_n are never low simultaneously. cas is never low while ras_n=1.

## Timing
- All outputs registered; they change only on clk rising edges, except on asynchronous reset.
- Request accepted at edge E0:
  - busy=1 from E0.
  - ROW from E0, RAS from E1, COL from E2, CAS from E3, HOLD from E4, PRE from E5.
  - done=1 for one cycle from E5. Access latency is 5 cycles.
  - busy falls at E5+TRP. A new req can be accepted at the edge where busy=0 is sampled.
- Refresh: RROW 1 cycle, RRAS 2 cycles, PRE TRP cycles. Total 3+TRP cycles with ras_n low for exactly 2 cycles.
- Worst-case request latency (refresh collision): 3+TRP+5 cycles from acceptance to done.
- req asserted while busy=1 is ignored. No error is flagged and the request is not queued.
- Reset asserted mid-access: strobes deassert immediately and no done pulse is produced. After release, the first refresh comes REFRESH_INTERVAL cycles later.

## Test plan
- Reset: hold reset_n=0 for 2 cycles → ma=00, ras_n=cas0_n=cas1_n=we_n=1, busy=0, done=0.
- Read bank 0, ta=16'hD512, rw=1:
  - ma=8'h12 during RAS, 8'hD5 at CAS.
  - cas0_n low exactly 2 cycles, cas1_n high, we_n high.
  - done exactly 5 cycles after acceptance; busy low 5+TRP cycles after acceptance.
- Write bank 1, ta=16'h0203, rw=0: cas1_n low 2 cycles, cas0_n stays 1, we_n=0 from COL through HOLD, done pulse once.
- Refresh sweep, REFRESH_INTERVAL=16, no requests: 256 refreshes present ma=00..FF in order, then 00 again. ras_n low 2 cycles each, cas never low.
- Collision: req in the same cycle ref_pending is serviced → refresh runs first (ras_n only, ma=refresh row), then the access completes with done at 3+TRP+5 cycles.
- Reset mid-access: assert reset_n=0 during the CAS state → all strobes 1 asynchronously, no done. Next request after reset completes normally.

Source files
------------

// File: rtl/dram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dram_ctrl
// Purpose  : Sequential controller for two 64 KB DRAM banks behind the
//            mmu8722. Multiplexes the translated address onto ma, times the
//            RAS/CAS/WE strobes for single accesses and interleaves periodic
//            RAS-only refresh, with refresh taking priority over CPU access.
// Ports    : clk      - system clock, rising edge
//            reset_n  - asynchronous active-low reset
//            req      - single-cycle access request (taken when busy=0)
//            rw       - 1=read, 0=write (sampled with req)
//            ta       - translated address (sampled with req)
//            bank     - bank select, 0->cas0_n, 1->cas1_n (sampled with req)
//            ma       - multiplexed DRAM address
//            ras_n    - row strobe, shared by both banks
//            cas0_n   - column strobe, bank 0
//            cas1_n   - column strobe, bank 1
//            we_n     - DRAM write enable
//            busy     - controller not accepting requests
//            done     - one-cycle pulse, access complete / read data valid
// Revision : 1.0 - initial release
// ============================================================================
module dram_ctrl #(
    parameter int REFRESH_INTERVAL = 124,
    parameter int TRP              = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] ta,
    input  logic        bank,
    output logic [7:0]  ma,
    output logic        ras_n,
    output logic        cas0_n,
    output logic        cas1_n,
    output logic        we_n,
    output logic        busy,
    output logic        done
);

    localparam int TW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int PW = $clog2(TRP + 1);
    localparam logic [TW-1:0] c_TMR_MAX  = TW'(REFRESH_INTERVAL - 1);
    localparam logic [PW-1:0] c_PRE_LAST = PW'(TRP - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ROW   = 4'd1,
        S_RAS   = 4'd2,
        S_COL   = 4'd3,
        S_CAS   = 4'd4,
        S_HOLD  = 4'd5,
        S_PRE   = 4'd6,
        S_RROW  = 4'd7,
        S_RRAS  = 4'd8,
        S_RRAS2 = 4'd9
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_tmr;
    logic            r_ref_pending;
    logic            r_req_pending;
    logic [15:0]     r_ta;
    logic            r_rw;
    logic            r_bank;
    logic [7:0]      r_row;
    logic [PW-1:0]   r_pre_cnt;

    logic            w_tmr_fire;
    logic            w_accept;
    logic            w_ref_want;
    logic            w_req_want;
    logic            w_pre_last;
    logic [7:0]      w_ta_lo;
    logic            w_ref_pending_nxt;
    logic            w_req_pending_nxt;
    logic [PW-1:0]   w_pre_cnt_nxt;
    logic [7:0]      w_ma_nxt;
    logic            w_ras_n_nxt;
    logic            w_cas0_n_nxt;
    logic            w_cas1_n_nxt;
    logic            w_we_n_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_cas_act;
    logic            w_we_act;

    // Next-state and next-output logic. Every output is registered, so the
    // values below are what the outputs become at the coming edge.
    always_comb begin
        w_tmr_fire = (r_tmr == c_TMR_MAX);
        w_accept   = req & ~busy;
        // A timer wrap on this very edge counts as a pending refresh, so a
        // request accepted at the same edge is held behind that refresh.
        w_ref_want = r_ref_pending | w_tmr_fire;
        w_req_want = r_req_pending | w_accept;
        w_pre_last = (r_pre_cnt == c_PRE_LAST);
        // The row byte must be driven on the acceptance edge itself, before
        // the latched copy exists.
        w_ta_lo    = w_accept ? ta[7:0] : r_ta[7:0];

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ref_want)      w_state_nxt = S_RROW;
                else if (w_req_want) w_state_nxt = S_ROW;
            end
            S_ROW:   w_state_nxt = S_RAS;
            S_RAS:   w_state_nxt = S_COL;
            S_COL:   w_state_nxt = S_CAS;
            S_CAS:   w_state_nxt = S_HOLD;
            S_HOLD:  w_state_nxt = S_PRE;
            S_PRE: begin
                // Arbitrate directly out of precharge so a held request
                // starts without an extra idle cycle.
                if (w_pre_last) begin
                    if (w_ref_want)      w_state_nxt = S_RROW;
                    else if (w_req_want) w_state_nxt = S_ROW;
                    else                 w_state_nxt = S_IDLE;
                end
            end
            S_RROW:  w_state_nxt = S_RRAS;
            S_RRAS:  w_state_nxt = S_RRAS2;
            S_RRAS2: w_state_nxt = S_PRE;
            default: w_state_nxt = S_IDLE;
        endcase

        w_ref_pending_nxt = w_ref_want;
        if (w_state_nxt == S_RROW) w_ref_pending_nxt = 1'b0;

        w_req_pending_nxt = w_req_want;
        if ((r_state == S_HOLD) && (w_state_nxt == S_PRE)) w_req_pending_nxt = 1'b0;

        w_pre_cnt_nxt = '0;
        if ((r_state == S_PRE) && (w_state_nxt == S_PRE)) w_pre_cnt_nxt = r_pre_cnt + PW'(1);

        w_ma_nxt = ma;
        case (w_state_nxt)
            S_ROW:   w_ma_nxt = w_ta_lo;
            S_COL:   w_ma_nxt = r_ta[15:8];
            S_RROW:  w_ma_nxt = r_row;
            default: w_ma_nxt = ma;
        endcase

        w_ras_n_nxt = 1'b1;
        case (w_state_nxt)
            S_RAS, S_COL, S_CAS, S_HOLD, S_RRAS, S_RRAS2: w_ras_n_nxt = 1'b0;
            default:                                      w_ras_n_nxt = 1'b1;
        endcase

        w_cas_act    = (w_state_nxt == S_CAS) || (w_state_nxt == S_HOLD);
        w_we_act     = (w_state_nxt == S_COL) || w_cas_act;
        w_cas0_n_nxt = ~(w_cas_act & ~r_bank);
        w_cas1_n_nxt = ~(w_cas_act &  r_bank);
        w_we_n_nxt   = ~(w_we_act & ~r_rw);

        w_done_nxt = (r_state == S_HOLD);
        w_busy_nxt = (w_state_nxt != S_IDLE) | w_ref_pending_nxt | w_req_pending_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_tmr         <= '0;
            r_ref_pending <= 1'b0;
            r_req_pending <= 1'b0;
            r_ta          <= '0;
            r_rw          <= 1'b1;
            r_bank        <= 1'b0;
            r_row         <= 8'h00;
            r_pre_cnt     <= '0;
            ma            <= 8'h00;
            ras_n         <= 1'b1;
            cas0_n        <= 1'b1;
            cas1_n        <= 1'b1;
            we_n          <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tmr         <= w_tmr_fire ? '0 : r_tmr + TW'(1);
            r_ref_pending <= w_ref_pending_nxt;
            r_req_pending <= w_req_pending_nxt;
            if (w_accept) begin
                r_ta   <= ta;
                r_rw   <= rw;
                r_bank <= bank;
            end
            if (r_state == S_RRAS2) r_row <= r_row + 8'd1;
            r_pre_cnt     <= w_pre_cnt_nxt;
            ma            <= w_ma_nxt;
            ras_n         <= w_ras_n_nxt;
            cas0_n        <= w_cas0_n_nxt;
            cas1_n        <= w_cas1_n_nxt;
            we_n          <= w_we_n_nxt;
            busy          <= w_busy_nxt;
            done          <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_ctrl
// Purpose  : Directed self-checking bench for dram_ctrl (REFRESH_INTERVAL=16,
//            TRP=2): reset, read, write, refresh sweep, refresh/request
//            collision and reset in the middle of an access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_ctrl;

    localparam int RI  = 16;
    localparam int TRP = 2;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        req     = 1'b0;
    logic        rw      = 1'b1;
    logic [15:0] ta      = 16'h0000;
    logic        bank    = 1'b0;
    logic [7:0]  ma;
    logic        ras_n;
    logic        cas0_n;
    logic        cas1_n;
    logic        we_n;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    // Per-cycle samples of one access window, index k = edges after acceptance
    logic [7:0]  s_ma [0:15];
    logic [15:0] v_ras, v_cas0, v_cas1, v_we, v_busy, v_done;

    always #5 clk = ~clk;

    dram_ctrl #(
        .REFRESH_INTERVAL (RI),
        .TRP              (TRP)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .rw      (rw),
        .ta      (ta),
        .bank    (bank),
        .ma      (ma),
        .ras_n   (ras_n),
        .cas0_n  (cas0_n),
        .cas1_n  (cas1_n),
        .we_n    (we_n),
        .busy    (busy),
        .done    (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int count_ones(input logic [15:0] v, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (v[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_idx(input logic [15:0] v, input logic val, input int n);
        for (int i = 0; i < n; i++) if (v[i] === val) return i;
        return -1;
    endfunction

    // Holds reset for two cycles, checks the reset state and releases it
    // just after an edge; the following edge is edge 1 of the timer.
    task automatic do_reset;
        req     = 1'b0;
        reset_n = 1'b0;
        tick;
        tick;
        check_eq("rst_ma", ma, 8'h00);
        check_eq("rst_strobes", {ras_n, cas0_n, cas1_n, we_n}, 4'hF);
        check_eq("rst_busy_done", {busy, done}, 2'b00);
        reset_n = 1'b1;
    endtask

    // Presents a request before the next edge (E0) and records n samples.
    // stray_k >= 0 pulses a second request while busy, which must be ignored.
    task automatic run_access(input logic [15:0] a, input logic r, input logic b,
                              input int n, input int stray_k);
        ta   = a;
        rw   = r;
        bank = b;
        req  = 1'b1;
        v_ras = '1; v_cas0 = '1; v_cas1 = '1; v_we = '1; v_busy = '0; v_done = '0;
        for (int k = 0; k < n; k++) begin
            tick;
            req = 1'b0;
            s_ma[k]   = ma;
            v_ras[k]  = ras_n;
            v_cas0[k] = cas0_n;
            v_cas1[k] = cas1_n;
            v_we[k]   = we_n;
            v_busy[k] = busy;
            v_done[k] = done;
            if (k == stray_k) begin
                req  = 1'b1;
                ta   = 16'hFFFF;
                rw   = ~r;
                bank = ~b;
            end
        end
        req = 1'b0;
    endtask

    initial begin
        int falls, rises, last_fall, run, cas_bad;
        logic prev;

        // ---------------- read, bank 0 ----------------
        do_reset;
        run_access(16'hD512, 1'b1, 1'b0, 10, 2);
        check_eq("rd_busy_e0", v_busy[0], 1'b1);
        check_eq("rd_ma_ras", s_ma[1], 8'h12);
        check_eq("rd_ma_cas", s_ma[3], 8'hD5);
        check_eq("rd_ras_low_cnt", count_ones(~v_ras, 10), 4);
        check_eq("rd_cas0_low_cnt", count_ones(~v_cas0, 10), 2);
        check_eq("rd_cas0_first", first_idx(v_cas0, 1'b0, 10), 3);
        check_eq("rd_cas1_low_cnt", count_ones(~v_cas1, 10), 0);
        check_eq("rd_we_low_cnt", count_ones(~v_we, 10), 0);
        check_eq("rd_done_cnt", count_ones(v_done, 10), 1);
        check_eq("rd_done_idx", first_idx(v_done, 1'b1, 10), 5);
        check_eq("rd_busy_fall", first_idx(v_busy, 1'b0, 10), 5 + TRP);

        // ---------------- write, bank 1 ----------------
        do_reset;
        run_access(16'h0203, 1'b0, 1'b1, 10, -1);
        check_eq("wr_ma_ras", s_ma[1], 8'h03);
        check_eq("wr_ma_cas", s_ma[3], 8'h02);
        check_eq("wr_cas1_low_cnt", count_ones(~v_cas1, 10), 2);
        check_eq("wr_cas0_low_cnt", count_ones(~v_cas0, 10), 0);
        check_eq("wr_we_low_cnt", count_ones(~v_we, 10), 3);
        check_eq("wr_we_first", first_idx(v_we, 1'b0, 10), 2);
        check_eq("wr_done_cnt", count_ones(v_done, 10), 1);
        check_eq("wr_done_idx", first_idx(v_done, 1'b1, 10), 5);

        // ---------------- collision: request on the refresh edge (16) ----------------
        do_reset;
        for (int i = 0; i < RI - 1; i++) tick;
        run_access(16'hA5C3, 1'b1, 1'b1, 14, -1);
        check_eq("col_ref_row", s_ma[0], 8'h00);
        check_eq("col_ras_first", first_idx(v_ras, 1'b0, 14), 1);
        check_eq("col_ras_low_cnt", count_ones(~v_ras, 14), 6);
        check_eq("col_ma_row", s_ma[5], 8'hC3);
        check_eq("col_ma_col", s_ma[7], 8'hA5);
        check_eq("col_cas1_first", first_idx(v_cas1, 1'b0, 14), 8);
        check_eq("col_cas1_low_cnt", count_ones(~v_cas1, 14), 2);
        check_eq("col_cas0_low_cnt", count_ones(~v_cas0, 14), 0);
        check_eq("col_done_idx", first_idx(v_done, 1'b1, 14), 3 + TRP + 5);
        check_eq("col_done_cnt", count_ones(v_done, 14), 1);
        check_eq("col_busy_fall", first_idx(v_busy, 1'b0, 14), 3 + TRP + 5 + TRP);

        // ---------------- reset in the middle of an access ----------------
        do_reset;
        run_access(16'h1234, 1'b1, 1'b0, 4, -1);
        check_eq("mid_cas_before", v_cas0[3], 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_async_strobes", {ras_n, cas0_n, cas1_n, we_n}, 4'hF);
        check_eq("mid_async_busy_done", {busy, done}, 2'b00);
        tick;
        tick;
        check_eq("mid_no_done", done, 1'b0);
        reset_n = 1'b1;
        run_access(16'h5678, 1'b0, 1'b0, 10, -1);
        check_eq("mid_next_ma_row", s_ma[1], 8'h78);
        check_eq("mid_next_cas0_cnt", count_ones(~v_cas0, 10), 2);
        check_eq("mid_next_done_idx", first_idx(v_done, 1'b1, 10), 5);

        // ---------------- refresh sweep: 257 refreshes, rows 00..FF then 00 ----------------
        do_reset;
        falls = 0; rises = 0; last_fall = 0; run = 0; cas_bad = 0; prev = 1'b1;
        for (int c = 1; c <= RI * 260 && rises < 257; c++) begin
            tick;
            if (!cas0_n || !cas1_n) cas_bad++;
            if (prev && !ras_n) begin
                if (falls == 0) check_eq("ref_first", c, RI + 1);
                else            check_eq("ref_spacing", c - last_fall, RI);
                check_eq("ref_row", ma, falls % 256);
                last_fall = c;
                falls++;
                run = 0;
            end
            if (!ras_n) run++;
            if (!prev && ras_n) begin
                check_eq("ref_ras_len", run, 2);
                rises++;
            end
            prev = ras_n;
        end
        check_eq("ref_count", rises, 257);
        check_eq("ref_cas_high", cas_bad, 0);
        check_eq("ref_no_done", done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
